can_bit_sampler: RTL and testbench
==================================

CAN_BIT_SAMPLER -- requirements
Module: can_bit_sampler

Interface
REQ-001 The module SHALL have parameter clk_speed_MHz, default 100, the system clock frequency in MHz.
REQ-002 The module SHALL have parameter can_bit_rate_Kbits, default 1000, the CAN bit rate in Kbit/s.
REQ-003 The module SHALL have parameter sample_pct, default 75, the sample point as a percent of the bit time.
REQ-004 The module SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 The module SHALL have port can_rx  input  1  CAN bus level (1 = recessive, 0 = dominant).
REQ-007 The module SHALL have port sof_detect  input  1  one-cycle start-of-frame strobe from frame_detect.
REQ-008 The module SHALL have port stuff_en  input  1  high while the frame parser is inside the stuffed region (SOF through CRC).
REQ-009 The module SHALL have port frame_done  input  1  one-cycle strobe from the parser ending the frame.
REQ-010 The module SHALL have port rx_bit  output  1  destuffed bit value, qualified by rx_bit_valid.
REQ-011 The module SHALL have port rx_bit_valid  output  1  one-cycle strobe per emitted data bit.
REQ-012 The module SHALL have port bit_index  output  8  index of the bit on rx_bit, valid with rx_bit_valid.
REQ-013 The module SHALL have port stuff_err  output  1  one-cycle strobe on a stuff rule violation.
REQ-014 The module SHALL have port busy  output  1  high while in state ACTIVE.

Function
REQ-015 The module SHALL define BIT_CYC = (clk_speed_MHz*1000)/can_bit_rate_Kbits (100 at defaults) and SAMPLE_CNT = BIT_CYC*sample_pct/100 (75 at defaults), both integer-truncated.
REQ-016 The module SHALL implement a bit-time counter of width $clog2(BIT_CYC) counting 0..BIT_CYC-1, then wrapping to 0.
REQ-017 The module SHALL have exactly two states: IDLE (busy=0, counters held at 0) and ACTIVE (busy=1).
REQ-018 In IDLE, a cycle with sof_detect=1 SHALL move the block to ACTIVE with bit-time counter=1, run counter=0 and bit index=0.
REQ-019 sof_detect SHALL be ignored while the block is in ACTIVE.
REQ-020 The module SHALL register can_rx each cycle into rx_d; a falling edge is defined as rx_d=1 and can_rx=0.
REQ-021 In ACTIVE, a falling edge with counter != SAMPLE_CNT SHALL load the counter with 1 (resynchronisation); otherwise the counter increments.
REQ-022 In ACTIVE, when counter == SAMPLE_CNT, can_rx SHALL be sampled, and any coincident edge is ignored.
REQ-023 Destuffing: the run counter (0..5) and last value SHALL track consecutive identical samples; the SOF sample counts toward the run.
REQ-024 With stuff_en=1 and run=5, a sample opposite to the last value SHALL be discarded as a stuff bit, with no rx_bit_valid, run=1 and last=sample.
REQ-025 With stuff_en=1 and run=5, a sample equal to the last value SHALL pulse stuff_err for one cycle, emit no rx_bit_valid, and move the block to IDLE on the next cycle.
REQ-026 With stuff_en=0, the run counter SHALL be held at 0 and every sample emitted.
REQ-027 Every non-discarded sample SHALL be emitted on the cycle after the sample: rx_bit=sample, rx_bit_valid=1, bit_index=current index; the index then increments and saturates at 255.
REQ-028 frame_done=1 in ACTIVE SHALL return the block to IDLE next cycle; if it coincides with a sample, frame_done wins and nothing is emitted.
REQ-029 rx_bit_valid and stuff_err SHALL never assert in the same cycle, and neither SHALL assert in IDLE except the final stuff_err/valid registered from ACTIVE.

Reset
REQ-030 When rst_n=0 at a rising clk edge, the module SHALL go to IDLE with rx_bit=0, rx_bit_valid=0, bit_index=0, stuff_err=0, busy=0, rx_d=1, and all counters at 0, including mid-frame.
REQ-031 While rst_n=0, the module SHALL ignore sof_detect.

Verification
REQ-032 sof_detect at cycle T with can_rx=0 held -> rx_bit_valid at T+75 with rx_bit=0 and bit_index=0, then again at T+175 with bit_index=1.
REQ-033 stuff_en=1, SOF plus 4 dominant bits, then 1 recessive bit, then 1 dominant bit -> 5 valids (indices 0-4), no valid for the 6th bit, 7th bit emitted with bit_index=5 and rx_bit=0.
REQ-034 stuff_en=1 and 6 dominant bits -> stuff_err pulse at T+575, no 6th valid, busy=0 from T+576.
REQ-035 Recessive bit after SOF, with a falling edge injected at counter=40 -> counter reloads to 1, and the next sample occurs 74 cycles after the edge.
REQ-036 rst_n=0 for one clock mid-frame (counter=50) -> all outputs 0 on the next cycle, and no further valids until a new sof_detect.
REQ-037 frame_done coincident with a sample cycle -> no rx_bit_valid, busy=0 on the next cycle, and a later sof_detect restarts with bit_index=0.

Source files
------------

// File: rtl/can_bit_sampler.sv
// rtl/can_bit_sampler.sv - CAN bit timing recovery, sample point capture and bit destuffing
//
// Purpose:
//   Recovers CAN bit timing from the bus, samples can_rx at a configurable
//   sample point, removes stuff bits inside the stuffed region and reports
//   stuff rule violations.
//
// Parameters:
//   clk_speed_MHz      system clock frequency in MHz
//   can_bit_rate_Kbits CAN bit rate in Kbit/s
//   sample_pct         sample point as a percent of the bit time
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   can_rx        bus level (1 = recessive, 0 = dominant)
//   sof_detect    one-cycle start-of-frame strobe, starts a frame from IDLE
//   stuff_en      high while the parser is inside the stuffed region
//   frame_done    one-cycle strobe ending the frame
//   rx_bit        destuffed bit value, qualified by rx_bit_valid
//   rx_bit_valid  one-cycle strobe per emitted data bit
//   bit_index     index of the bit on rx_bit (saturates at 255)
//   stuff_err     one-cycle strobe on a stuff rule violation
//   busy          high while a frame is being sampled

module can_bit_sampler #(
    parameter int clk_speed_MHz      = 100,
    parameter int can_bit_rate_Kbits = 1000,
    parameter int sample_pct         = 75
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       can_rx,
    input  logic       sof_detect,
    input  logic       stuff_en,
    input  logic       frame_done,
    output logic       rx_bit,
    output logic       rx_bit_valid,
    output logic [7:0] bit_index,
    output logic       stuff_err,
    output logic       busy
);

    localparam int BIT_CYC    = (clk_speed_MHz * 1000) / can_bit_rate_Kbits;
    localparam int SAMPLE_CNT = BIT_CYC * sample_pct / 100;
    localparam int CNT_W      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    // Five identical samples in a row force a stuff bit of opposite value.
    localparam logic [2:0] RUN_MAX = 3'd5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_inc;
    logic [2:0]       run_cnt;
    logic             last_val;
    logic [7:0]       bit_idx;
    logic             rx_d;

    logic             fall_edge;
    logic             at_sample;
    logic             sample_hit;
    logic             leave_frame;
    logic             do_emit;
    logic             do_discard;
    logic             do_violate;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // A stuff violation is reported while still ACTIVE; the registered
    // stuff_err then drops the block to IDLE one cycle later. frame_done
    // leaves immediately.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sof_detect) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (frame_done || stuff_err) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state == ACTIVE);
    end

    // ------------------------------------------------------------------
    // Bit timing and sample decode
    // ------------------------------------------------------------------
    assign fall_edge   = rx_d && !can_rx;
    assign bit_cnt_inc = (bit_cnt == CNT_LAST) ? CNT_ZERO : bit_cnt + CNT_ONE;
    assign leave_frame = frame_done || stuff_err;
    assign at_sample   = (bit_cnt == CNT_SAMPLE);

    // frame_done wins over a coincident sample, so nothing is emitted then.
    assign sample_hit  = (state == ACTIVE) && at_sample && !leave_frame;

    always_comb begin
        do_emit    = 1'b0;
        do_discard = 1'b0;
        do_violate = 1'b0;
        if (sample_hit) begin
            if (stuff_en && (run_cnt == RUN_MAX)) begin
                if (can_rx != last_val) begin
                    do_discard = 1'b1;
                end else begin
                    do_violate = 1'b1;
                end
            end else begin
                do_emit = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath: counters, run tracking and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_d         <= 1'b1;
            bit_cnt      <= CNT_ZERO;
            run_cnt      <= 3'd0;
            last_val     <= 1'b0;
            bit_idx      <= 8'd0;
            rx_bit       <= 1'b0;
            rx_bit_valid <= 1'b0;
            bit_index    <= 8'd0;
            stuff_err    <= 1'b0;
        end else begin
            rx_d         <= can_rx;
            rx_bit_valid <= 1'b0;
            stuff_err    <= 1'b0;

            if (state == IDLE) begin
                // Counters rest at zero; SOF marks the start of bit 0, so
                // the bit-time counter starts at 1.
                bit_cnt  <= sof_detect ? CNT_ONE : CNT_ZERO;
                run_cnt  <= 3'd0;
                last_val <= 1'b0;
                bit_idx  <= 8'd0;
            end else if (leave_frame) begin
                bit_cnt  <= CNT_ZERO;
                run_cnt  <= 3'd0;
                last_val <= 1'b0;
                bit_idx  <= 8'd0;
            end else begin
                // Hard resync on any falling edge except at the sample point,
                // where the edge belongs to the sampled bit and is ignored.
                if (at_sample) begin
                    bit_cnt <= bit_cnt_inc;
                end else if (fall_edge) begin
                    bit_cnt <= CNT_ONE;
                end else begin
                    bit_cnt <= bit_cnt_inc;
                end

                if (sample_hit) begin
                    last_val <= can_rx;
                    if (!stuff_en) begin
                        run_cnt <= 3'd0;
                    end else if (do_discard) begin
                        run_cnt <= 3'd1;
                    end else if (!do_violate) begin
                        // A fresh run (count 0) or a change of level restarts at 1.
                        if ((run_cnt == 3'd0) || (can_rx != last_val)) begin
                            run_cnt <= 3'd1;
                        end else begin
                            run_cnt <= run_cnt + 3'd1;
                        end
                    end
                end

                if (do_emit) begin
                    rx_bit       <= can_rx;
                    rx_bit_valid <= 1'b1;
                    bit_index    <= bit_idx;
                    if (bit_idx != 8'hFF) begin
                        bit_idx <= bit_idx + 8'd1;
                    end
                end

                if (do_violate) begin
                    stuff_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_can_bit_sampler.sv
// tb/tb_can_bit_sampler.sv - scoreboard testbench for can_bit_sampler

module tb_can_bit_sampler;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       can_rx     = 1'b1;
    logic       sof_detect = 1'b0;
    logic       stuff_en   = 1'b0;
    logic       frame_done = 1'b0;
    logic       rx_bit;
    logic       rx_bit_valid;
    logic [7:0] bit_index;
    logic       stuff_err;
    logic       busy;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit is_err;
        bit b;
        int idx;
        int at;
    } exp_t;

    exp_t sb[$];

    can_bit_sampler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .can_rx       (can_rx),
        .sof_detect   (sof_detect),
        .stuff_en     (stuff_en),
        .frame_done   (frame_done),
        .rx_bit       (rx_bit),
        .rx_bit_valid (rx_bit_valid),
        .bit_index    (bit_index),
        .stuff_err    (stuff_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
        $fatal(1);
    end

    // Monitor: every strobe from the DUT must match the head of the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rx_bit_valid || stuff_err) begin
            checks++;
            if (rx_bit_valid && stuff_err) begin
                errors++;
                $display("FAIL both_strobes: cyc=%0d valid=1 err=1, required at most one", cyc);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: cyc=%0d valid=%0b err=%0b idx=%0d bit=%0b, required none",
                         cyc, rx_bit_valid, stuff_err, bit_index, rx_bit);
            end else begin
                e = sb.pop_front();
                if ((e.is_err != stuff_err) || (e.at != cyc) ||
                    (!e.is_err && ((e.b != rx_bit) || (e.idx != int'(bit_index))))) begin
                    errors++;
                    $display("FAIL output_event: got cyc=%0d err=%0b bit=%0b idx=%0d, required cyc=%0d err=%0b bit=%0b idx=%0d",
                             cyc, stuff_err, rx_bit, bit_index, e.at, e.is_err, e.b, e.idx);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_valid(input bit b, input int idx, input int at);
        exp_t e;
        e.is_err = 1'b0;
        e.b      = b;
        e.idx    = idx;
        e.at     = at;
        sb.push_back(e);
    endtask

    task automatic push_err(input int at);
        exp_t e;
        e.is_err = 1'b1;
        e.b      = 1'b0;
        e.idx    = 0;
        e.at     = at;
        sb.push_back(e);
    endtask

    // Drive the SOF strobe; t is the cycle in which the block becomes ACTIVE.
    task automatic start_frame(input logic rx, output int t);
        can_rx     = rx;
        sof_detect = 1'b1;
        tick();
        t          = cyc;
        sof_detect = 1'b0;
        chk("busy_after_sof", int'(busy), 1);
    endtask

    task automatic end_frame(input string name);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        chk({name, "_busy_after_done"}, int'(busy), 0);
        repeat (5) tick();
        chk({name, "_sb_drained"}, sb.size(), 0);
    endtask

    initial begin
        int t;

        // Reset state, with sof_detect held high to show it is ignored.
        rst_n      = 1'b0;
        sof_detect = 1'b1;
        repeat (3) tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(rx_bit_valid), 0);
        chk("reset_index", int'(bit_index), 0);
        chk("reset_stuff_err", int'(stuff_err), 0);
        chk("reset_rx_bit", int'(rx_bit), 0);
        sof_detect = 1'b0;
        rst_n      = 1'b1;
        repeat (3) tick();
        chk("idle_busy", int'(busy), 0);

        // Dominant bus, no stuffing: samples at T+75 and T+175.
        stuff_en = 1'b0;
        start_frame(1'b0, t);
        push_valid(1'b0, 0, t + 75);
        push_valid(1'b0, 1, t + 175);
        wait_until(t + 180);
        end_frame("basic");

        // Stuff bit removal: 5 dominant, stuff recessive, then dominant.
        stuff_en = 1'b1;
        start_frame(1'b0, t);
        for (int k = 0; k < 5; k++) push_valid(1'b0, k, t + 75 + 100 * k);
        wait_until(t + 499);
        can_rx = 1'b1;
        wait_until(t + 599);
        can_rx = 1'b0;
        push_valid(1'b0, 5, t + 675);
        wait_until(t + 690);
        end_frame("destuff");
        stuff_en = 1'b0;

        // Stuff violation: 6 dominant bits in a row.
        stuff_en = 1'b1;
        start_frame(1'b0, t);
        for (int k = 0; k < 5; k++) push_valid(1'b0, k, t + 75 + 100 * k);
        push_err(t + 575);
        wait_until(t + 575);
        chk("stuff_err_busy_held", int'(busy), 1);
        wait_until(t + 576);
        chk("stuff_err_busy_dropped", int'(busy), 0);
        repeat (5) tick();
        chk("stuff_err_sb_drained", sb.size(), 0);
        stuff_en = 1'b0;

        // Resynchronisation: falling edge at counter=40 in a recessive bit.
        start_frame(1'b0, t);
        push_valid(1'b0, 0, t + 75);
        wait_until(t + 99);
        can_rx = 1'b1;
        wait_until(t + 139);
        can_rx = 1'b0;
        push_valid(1'b0, 1, t + 215);
        wait_until(t + 220);
        end_frame("resync");

        // Mid-frame reset at counter=50 of bit 2, with sof_detect during reset.
        start_frame(1'b1, t);
        push_valid(1'b1, 0, t + 75);
        push_valid(1'b1, 1, t + 175);
        wait_until(t + 249);
        rst_n      = 1'b0;
        sof_detect = 1'b1;
        tick();
        rst_n      = 1'b1;
        sof_detect = 1'b0;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_valid", int'(rx_bit_valid), 0);
        chk("midreset_index", int'(bit_index), 0);
        chk("midreset_rx_bit", int'(rx_bit), 0);
        chk("midreset_stuff_err", int'(stuff_err), 0);
        repeat (300) tick();
        chk("midreset_stays_idle", int'(busy), 0);
        chk("midreset_sb_drained", sb.size(), 0);

        // frame_done coincident with the bit-1 sample, then a clean restart.
        start_frame(1'b0, t);
        push_valid(1'b0, 0, t + 75);
        wait_until(t + 174);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        chk("done_on_sample_busy", int'(busy), 0);
        repeat (5) tick();
        chk("done_on_sample_sb_drained", sb.size(), 0);
        start_frame(1'b0, t);
        push_valid(1'b0, 0, t + 75);
        wait_until(t + 80);
        end_frame("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
